// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Takes one byte per valid/ready handshake and
// runs the full host transmission on the open-drain PS/2 pins: clock inhibit,
// request-to-send (start bit), 8 data bits LSB first, odd parity, stop bit and
// the device acknowledge. Reports a one-cycle done (acked) or err (NACK or
// timeout) pulse.
//
// Optional feature: define PS2_TX_TIMEOUT_EN to enable a watchdog that aborts
// a transfer when the device clock stalls for TIMEOUT_CYCLES clk cycles.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before RTS (>= 100 us)
//   TIMEOUT_CYCLES  max clk cycles between device clock falling edges
//                   (only present with PS2_TX_TIMEOUT_EN)
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   tx_data      in   byte to send, sampled on accept
//   tx_valid     in   send request, accepted when tx_valid && tx_ready
//   tx_ready     out  high only in IDLE
//   ps2_clk_in   in   raw PS/2 clock pin level (asynchronous)
//   ps2_data_in  in   raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe   out  1 = pull clock pin low, 0 = release
//   ps2_data_oe  out  1 = pull data pin low, 0 = release
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse: byte sent and acked by the device
//   err          out  one-cycle pulse: NACK or timeout
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2047
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int               INH_W    = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SHIFT     = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // -------------------------------------------------------------------------
    // Pin synchronizers and falling-edge detect on the device clock
    // -------------------------------------------------------------------------
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       clk_fall;
    logic       lines_idle;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a
    // spurious falling edge right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every flop samples the pre-edge value of its neighbours.
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_fall   = clk_prev_q & ~clk_sync_q[1];
    assign lines_idle = clk_sync_q[1] & data_sync_q[1];

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             ack_ok_q, ack_ok_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_err_q, to_err_d;
    logic            wd_expire;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_ok_d  = ack_ok_q;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = tx_data;
                    parity_d  = ~^tx_data;   // odd parity over the data byte
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    // Release clock and pull data low (start bit) together.
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            S_RTS: begin
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end

            S_SHIFT: begin
                // Present the next bit after each device falling edge; the
                // device samples it on the following rising edge.
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;    // stop bit: line released high
                        state_d   = S_ACK;
                    end
                end
            end

            S_ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_sync_q[1];
                    state_d  = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                // The result pulses while still busy, so tx_ready rises the
                // cycle after done/err.
                if (lines_idle) begin
                    done    = ack_ok_q;
                    err     = ~ack_ok_q;
                    state_d = S_IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        wd_d      = wd_q;
        to_err_d  = 1'b0;
        wd_expire = 1'b0;
        case (state_q)
            S_RTS: wd_d = '0;
            S_SHIFT, S_ACK: begin
                wd_d      = clk_fall ? '0 : wd_q + 1'b1;
                wd_expire = ~clk_fall & (wd_q == WD_LAST);
            end
            S_WAIT_IDLE: begin
                wd_d      = wd_q + 1'b1;
                wd_expire = ~lines_idle & (wd_q == WD_LAST);
            end
            default: wd_d = '0;
        endcase

        if (to_err_q) begin
            // Pins were released on the expiring cycle; report and go home.
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done      = 1'b0;
            err       = 1'b1;
            wd_d      = '0;
            state_d   = S_IDLE;
        end else if (wd_expire) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            to_err_d  = 1'b1;
            state_d   = state_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_ok_q  <= ack_ok_d;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q     <= '0;
            to_err_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            to_err_q <= to_err_d;
        end
    end
`endif

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Self-checking bench for ps2_host_tx. A behavioural PS/2 device drives the
// clock and wired-AND data pins; the bits it samples on each rising clock edge
// are compared against a scoreboard queue filled when each byte is accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 16;
    localparam int HALF    = 8;     // device half clock period in clk cycles
`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT = 100;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_pin;
    logic ps2_data_pin;

    // Open-drain lines: either side may pull low.
    assign ps2_clk_pin  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_pin = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT)
`ifdef PS2_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TIMEOUT)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_pin),
        .ps2_data_in(ps2_data_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [7:0] data;
        logic       parity;   // expected odd-parity bit on the line
        logic       ack;      // device acks (1) or NACKs (0)
    } vec_t;

    vec_t vecs[5];
    logic exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_seen = 0;
    int   err_seen  = 0;
    int   exp_done_total = 0;
    int   exp_err_total  = 0;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (err)  err_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one byte (called at a negedge), confirm the inhibit window length
    // and load the scoreboard with the expected line bits.
    task automatic start_tx(input logic [7:0] d, input logic par);
        int waited = 0;
        int cnt;
        while (!tx_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_accept", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("clk_oe_after_accept", ps2_clk_oe, 1);
        check("ready_low_after_accept", tx_ready, 0);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
        cnt = 1;
        while (ps2_clk_oe && cnt < 200) begin
            @(negedge clk);
            if (ps2_clk_oe) cnt++;
        end
        check("inhibit_len", cnt, INHIBIT);
        check("rts_data_low", ps2_data_pin, 0);
    endtask

    // Device generates n clock pulses and samples the data line on each rise.
    task automatic device_edges(input int n, input bit noise);
        logic exp_bit;
        for (int e = 1; e <= n; e++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            if (noise && e == 2) begin
                tx_valid = 1'b1;     // must be ignored while busy
                tx_data  = 8'h00;
            end
            if (noise && e == 3) tx_valid = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (exp_q.size() == 0) begin
                check($sformatf("scoreboard_empty_edge%0d", e), exp_q.size(), 1);
            end else begin
                exp_bit = exp_q.pop_front();
                check($sformatf("line_bit_edge%0d", e), ps2_data_pin, exp_bit);
            end
        end
    endtask

    // Edge 11: device pulls data low (ack) or leaves it high (NACK).
    task automatic device_ack(input bit ack);
        repeat (HALF) @(negedge clk);
        if (ack) dev_data = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    // Wait (bounded) for the result pulse, then check the cycle after it.
    task automatic wait_result(input bit exp_done, input bit exp_err,
                               input int bound, output int cycles);
        bit seen = 1'b0;
        bit got_done = 1'b0;
        bit got_err = 1'b0;
        cycles = 0;
        while (!seen && cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (done || err) begin
                seen     = 1'b1;
                got_done = done;
                got_err  = err;
                check("ready_low_during_pulse", tx_ready, 0);
            end
        end
        check("result_seen", seen, 1);
        check("done_value", got_done, exp_done);
        check("err_value", got_err, exp_err);
        @(negedge clk);
        check("pulse_one_cycle", {done, err}, 2'b00);
        check("ready_after_pulse", tx_ready, 1);
        check("pins_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        if (exp_done) exp_done_total++;
        if (exp_err)  exp_err_total++;
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int cyc;
        int d0;
        int e0;

        vecs[0] = '{data: 8'hED, parity: 1'b1, ack: 1'b1};
        vecs[1] = '{data: 8'hF4, parity: 1'b0, ack: 1'b1};
        vecs[2] = '{data: 8'hFF, parity: 1'b1, ack: 1'b1};
        vecs[3] = '{data: 8'hA5, parity: 1'b1, ack: 1'b0};
        vecs[4] = '{data: 8'h01, parity: 1'b0, ack: 1'b1};

        // Reset held over two clock edges.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done_err", {done, err}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        // Each byte starts on the first tx_ready cycle after the previous
        // result, covering back-to-back acceptance.
        for (int i = 0; i < 5; i++) begin
            start_tx(vecs[i].data, vecs[i].parity);
            device_edges(10, i == 0);
            device_ack(vecs[i].ack);
            wait_result(vecs[i].ack, !vecs[i].ack, 50, cyc);
        end

        // Reset in the middle of SHIFT, after edge 5.
        start_tx(8'h3C, 1'b1);
        device_edges(5, 1'b0);
        d0 = done_seen;
        e0 = err_seen;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pins_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        exp_q.delete();
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_seen, d0);
        check("midrst_no_err", err_seen, e0);

        start_tx(8'h55, 1'b1);
        device_edges(10, 1'b0);
        device_ack(1'b1);
        wait_result(1'b1, 1'b0, 50, cyc);

`ifdef PS2_TX_TIMEOUT_EN
        // Device stops clocking after edge 4; the watchdog must abort.
        start_tx(8'hA0, 1'b1);
        device_edges(4, 1'b0);
        exp_q.delete();
        wait_result(1'b0, 1'b1, 4 * TIMEOUT, cyc);
        // cyc counts from the rise of edge 4; the fall was HALF cycles
        // earlier, plus two synchronizer stages and the edge register.
        check("timeout_not_early", (cyc + HALF) >= TIMEOUT, 1);
        check("timeout_not_late", (cyc + HALF) <= TIMEOUT + 5, 1);
`endif

        check("done_total", done_seen, exp_done_total);
        check("err_total", err_seen, exp_err_total);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the sending end of the PS/2 link, for commands such as LED set 0xED, enable 0xF4 and reset 0xFF. Sits beside the PS/2 keyboard receiver in the top level and drives the open-drain clock/data pins through output-enable strobes. Accepts one byte per handshake and performs the full PS/2 host transmission: inhibit, request-to-send, 8 data bits, odd parity, stop bit and ack check. Reports completion or error to the CPU-side logic.

## Interface
- INHIBIT_CYCLES, 2047: clk cycles ps2 clock is held low before request-to-send; must be ≥100 µs at clk rate.
- TIMEOUT_CYCLES, 65535: max clk cycles between consecutive device clock falling edges; only used with PS2_TX_TIMEOUT_EN.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send, sampled on accept.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock pin low; 0 = release (pin tri-stated at top level).
- ps2_data_oe  out  1  1 = pull data pin low; 0 = release.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse: byte sent and device acked.
- err  out  1  one-cycle pulse: NACK or timeout.

## Operation
- ps2_clk_in/ps2_data_in pass through 2-FF synchronizers; falling edge = previous synced clock 1, current 0.
- States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
- IDLE: both oe = 0, tx_ready = 1. On accept, latch tx_data into 8-bit shift register. Compute parity = ~^tx_data (odd parity) and go to INHIBIT.
- INHIBIT: ps2_clk_oe = 1, ps2_data_oe = 0. Counter runs 0..INHIBIT_CYCLES-1, then go to RTS.
- RTS: ps2_data_oe = 1 (start bit 0), ps2_clk_oe = 0. Clear bit counter and go to SHIFT.
- SHIFT: on each device clock falling edge, bit counter n increments. Line values by edge:
  - edges 1..8: data bit D(n-1), LSB first; ps2_data_oe = ~bit.
  - edge 9: parity bit.
  - edge 10: stop bit; release data (oe = 0), then go to ACK.
- ACK: on next falling edge, sample synced data.
  - 0: ack OK; go to WAIT_IDLE with done pending.
  - 1: NACK; go to WAIT_IDLE with err pending.
- WAIT_IDLE: both oe = 0. When synced clock and data are both 1, pulse done or err, then go to IDLE.
- tx_valid outside IDLE is ignored; no queuing.
- Edges before RTS completes are ignored; the edge detector only acts in SHIFT/ACK.

## Timing
- Reset values: ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, done = 0, err = 0; state IDLE; counters 0.
- rst mid-transfer releases both pins on the next clk edge and returns to IDLE. No done or err is issued.
- Accept at cycle t: busy = 1 and ps2_clk_oe = 1 at t+1.
- ps2_clk_oe stays low for exactly INHIBIT_CYCLES cycles. ps2_data_oe rises on the cycle ps2_clk_oe falls.
- Data oe for a bit changes 3 clk after the raw pin falling edge (2 sync + 1 register). The device samples on the rising edge, so the margin is half a PS/2 clock period.
- done/err are exactly one cycle wide; tx_ready returns high the cycle after the pulse. The earliest next accept is that cycle.
- Simultaneous rst and tx_valid: rst wins.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A watchdog counter clears on every falling edge in SHIFT/ACK and on entry to RTS.
  - If it reaches TIMEOUT_CYCLES, release both pins, pulse err next cycle and return to IDLE, skipping WAIT_IDLE.
  - Also bounds WAIT_IDLE.
- Not defined: no watchdog. A missing device clock holds the block in SHIFT/ACK until rst.

## Test plan
- Reset: assert rst 2 cycles -> all oe 0, tx_ready 1, busy 0, done/err 0.
- Send 0xED with device model acking (INHIBIT_CYCLES = 16):
  - ps2_clk_oe high for exactly 16 cycles, then data low.
  - Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Data pulled low at edge 11 -> single done pulse, tx_ready back high.
- Send 0xF4 -> sampled bits 0,0,1,0,1,1,1,1, parity 0; done pulse; a second byte 0xFF is accepted the cycle after tx_ready rises.
- Device leaves data high at edge 11 (NACK) -> err pulse, no done, pins released.
- With PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES = 100, device stops clocking after edge 4 -> err within 101 cycles of edge 4, both oe 0, tx_ready 1.
- Assert rst during SHIFT after edge 5 -> both oe 0 next cycle, no done/err. A new 0x55 accepted afterwards is sent correctly with parity 1.
